// File: rtl/cam_btn_cmd_scheduler.sv
// Classifies debounced button presses as short/long, holds one pending event per
// button and grants them round-robin onto a single valid/ready command port.
module cam_btn_cmd_scheduler #(
   parameter  int NBTN        = 4,
   parameter  int LONG_CYCLES = 25000000,
   localparam int IDW         = $clog2(NBTN),
   localparam int CW          = $clog2(LONG_CYCLES + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NBTN-1:0] btn_level,
   input  logic [NBTN-1:0] btn_tick,
   output logic            cmd_valid,
   input  logic            cmd_ready,
   output logic [IDW-1:0]  cmd_id,
   output logic            cmd_long,
   output logic [NBTN-1:0] pending,
   output logic            overflow,
   input  logic            clr_overflow
);

   // state   | meaning
   // IDLE    | button released, waiting for a validated press tick
   // HELD    | press in progress, hold counter running
   // LATCHED | long event already posted, waiting for release
   typedef enum logic [1:0] {S_IDLE, S_HELD, S_LATCHED} btn_state_t;

   localparam logic [CW-1:0] CNT_LONG = CW'(LONG_CYCLES - 1);

   btn_state_t      state [NBTN];
   logic [CW-1:0]   cnt   [NBTN];
   logic [NBTN-1:0] pend;
   logic [NBTN-1:0] pend_long;
   logic [NBTN-1:0] post;
   logic [NBTN-1:0] post_long;
   logic [NBTN-1:0] grant;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  win;
   logic            found;
   logic            load;
   int              k;

   assign pending = pend;

   always_comb begin
      post      = '0;
      post_long = '0;
      for (int i = 0; i < NBTN; i++) begin
         if (state[i] == S_HELD) begin
            if (!btn_level[i]) begin
               post[i] = 1'b1;
            end else if (cnt[i] == CNT_LONG) begin
               post[i]      = 1'b1;
               post_long[i] = 1'b1;
            end
         end
      end
   end

   // Search starts just past the last winner so every button gets a turn.
   always_comb begin
      found = 1'b0;
      win   = '0;
      k     = 0;
      for (int j = 1; j <= NBTN; j++) begin
         k = (int'(ptr) + j) % NBTN;
         if (!found && pend[k[IDW-1:0]]) begin
            found = 1'b1;
            win   = k[IDW-1:0];
         end
      end
   end

   assign load = (!cmd_valid || cmd_ready) && found;

   always_comb begin
      grant = '0;
      if (load) grant[win] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NBTN; i++) begin
            state[i] <= S_IDLE;
            cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NBTN; i++) begin
            case (state[i])
               S_IDLE: begin
                  if (btn_tick[i]) begin
                     state[i] <= S_HELD;
                     cnt[i]   <= CW'(1);
                  end
               end
               S_HELD: begin
                  if (!btn_level[i]) begin
                     state[i] <= S_IDLE;
                     cnt[i]   <= '0;
                  end else if (cnt[i] == CNT_LONG) begin
                     state[i] <= S_LATCHED;
                  end else if (cnt[i] != '1) begin
                     cnt[i] <= cnt[i] + CW'(1);
                  end
               end
               S_LATCHED: begin
                  if (!btn_level[i]) begin
                     state[i] <= S_IDLE;
                     cnt[i]   <= '0;
                  end
               end
               default: begin
                  state[i] <= S_IDLE;
                  cnt[i]   <= '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_valid <= 1'b0;
         cmd_id    <= '0;
         cmd_long  <= 1'b0;
         ptr       <= '0;
         pend      <= '0;
         pend_long <= '0;
         overflow  <= 1'b0;
      end else begin
         if (load) begin
            cmd_valid <= 1'b1;
            cmd_id    <= win;
            cmd_long  <= pend_long[win];
            ptr       <= win;
         end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
         end
         // A fresh post beats a same-cycle grant clear of the same button.
         for (int i = 0; i < NBTN; i++) begin
            if (post[i] && (!pend[i] || grant[i])) begin
               pend[i]      <= 1'b1;
               pend_long[i] <= post_long[i];
            end else if (grant[i]) begin
               pend[i] <= 1'b0;
            end
         end
         if (|(post & pend & ~grant)) overflow <= 1'b1;
         else if (clr_overflow)       overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cam_btn_cmd_scheduler.sv
// Bench for cam_btn_cmd_scheduler: vector table, directed corner sequences and
// random button activity checked against a cycle-stamp reference model.
module tb_cam_btn_cmd_scheduler;
   localparam int NBTN = 4;
   localparam int LONG = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn_level = '0;
   logic [3:0] btn_tick = '0;
   logic       cmd_ready = 1'b0;
   logic       clr_overflow = 1'b0;
   logic       cmd_valid;
   logic [1:0] cmd_id;
   logic       cmd_long;
   logic [3:0] pending;
   logic       overflow;

   int n_checks = 0;
   int n_errors = 0;
   bit mon_en = 0;

   always #5 clk = ~clk;

   cam_btn_cmd_scheduler #(.NBTN(NBTN), .LONG_CYCLES(LONG)) dut (
      .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .btn_tick(btn_tick),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
      .cmd_long(cmd_long), .pending(pending), .overflow(overflow),
      .clr_overflow(clr_overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: presses tracked by the cycle they started, pending events
   // as plain per-button flags, the arbiter as a modular search.
   int         m_st [NBTN];   // 0 released, 1 pressed, 2 long already reported
   int         m_start [NBTN];
   int         cyc;
   bit         m_pend [NBTN];
   bit         m_plong [NBTN];
   bit         m_valid, m_long, m_ovf;
   int         m_id, m_ptr;

   task automatic model_reset();
      for (int i = 0; i < NBTN; i++) begin
         m_st[i] = 0; m_start[i] = 0; m_pend[i] = 0; m_plong[i] = 0;
      end
      m_valid = 0; m_long = 0; m_ovf = 0; m_id = 0; m_ptr = 0; cyc = 0;
   endtask

   task automatic model_step();
      bit post [NBTN];
      bit plong [NBTN];
      bit grant [NBTN];
      bit drop;
      int w;
      drop = 0;
      for (int i = 0; i < NBTN; i++) begin
         post[i] = 0; plong[i] = 0; grant[i] = 0;
         if (m_st[i] == 0) begin
            if (btn_tick[i]) begin m_st[i] = 1; m_start[i] = cyc; end
         end else if (m_st[i] == 1) begin
            if (!btn_level[i]) begin post[i] = 1; m_st[i] = 0; end
            else if (cyc - m_start[i] == LONG - 1) begin
               post[i] = 1; plong[i] = 1; m_st[i] = 2;
            end
         end else if (!btn_level[i]) m_st[i] = 0;
      end
      if (!m_valid || cmd_ready) begin
         w = -1;
         for (int j = 1; j <= NBTN; j++)
            if (w < 0 && m_pend[(m_ptr + j) % NBTN]) w = (m_ptr + j) % NBTN;
         if (w >= 0) begin
            m_valid = 1; m_id = w; m_long = m_plong[w]; m_ptr = w;
            m_pend[w] = 0; grant[w] = 1;
         end else m_valid = 0;
      end
      for (int i = 0; i < NBTN; i++) begin
         if (post[i]) begin
            if (m_pend[i] && !grant[i]) drop = 1;
            else begin m_pend[i] = 1; m_plong[i] = plong[i]; end
         end
      end
      if (drop) m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
      cyc++;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   initial begin
      logic [3:0] mp;
      forever begin
         @(negedge clk);
         if (rst_n && mon_en) begin
            for (int i = 0; i < NBTN; i++) mp[i] = m_pend[i];
            chk("model_valid", 32'(cmd_valid), 32'(m_valid));
            chk("model_pending", 32'(pending), 32'(mp));
            chk("model_overflow", 32'(overflow), 32'(m_ovf));
            if (m_valid) begin
               chk("model_id", 32'(cmd_id), 32'(m_id));
               chk("model_long", 32'(cmd_long), 32'(m_long));
            end
         end
      end
   end

   task automatic cyc_in(input logic [3:0] lv, input logic [3:0] tk,
                         input logic rdy, input logic clr);
      btn_level = lv; btn_tick = tk; cmd_ready = rdy; clr_overflow = clr;
      @(negedge clk);
   endtask

   task automatic do_reset();
      btn_level = '0; btn_tick = '0; cmd_ready = 0; clr_overflow = 0;
      rst_n = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] lv, tk;
      logic       rdy;
      logic       ev;
      logic [1:0] eid;
      logic       el;
      logic [3:0] ep;
   } vec_t;

   function automatic vec_t mk(logic r, logic [3:0] lv, logic [3:0] tk, logic rdy,
                               logic ev, logic [1:0] eid, logic el, logic [3:0] ep);
      vec_t v;
      v.rst = r; v.lv = lv; v.tk = tk; v.rdy = rdy;
      v.ev = ev; v.eid = eid; v.el = el; v.ep = ep;
      return v;
   endfunction

   initial begin
      vec_t tbl [13];
      int   waited;
      bit   seen;
      logic [3:0] lv, tk;

      // btn 2 short press, then btn 0/1/3 posting together with ptr=0
      tbl[0]  = mk(1, 4'b0100, 4'b0100, 1, 0, 0, 0, 4'b0000);
      tbl[1]  = mk(0, 4'b0100, 4'b0000, 1, 0, 0, 0, 4'b0000);
      tbl[2]  = mk(0, 4'b0100, 4'b0000, 1, 0, 0, 0, 4'b0000);
      tbl[3]  = mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0100);
      tbl[4]  = mk(0, 4'b0000, 4'b0000, 1, 1, 2, 0, 4'b0000);
      tbl[5]  = mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000);
      tbl[6]  = mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000);
      tbl[7]  = mk(1, 4'b1011, 4'b1011, 1, 0, 0, 0, 4'b0000);
      tbl[8]  = mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b1011);
      tbl[9]  = mk(0, 4'b0000, 4'b0000, 1, 1, 1, 0, 4'b1001);
      tbl[10] = mk(0, 4'b0000, 4'b0000, 1, 1, 3, 0, 4'b0001);
      tbl[11] = mk(0, 4'b0000, 4'b0000, 1, 1, 0, 0, 4'b0000);
      tbl[12] = mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000);

      @(negedge clk);
      do_reset();
      chk("reset_valid", 32'(cmd_valid), 0);
      chk("reset_id", 32'(cmd_id), 0);
      chk("reset_pending", 32'(pending), 0);
      chk("reset_overflow", 32'(overflow), 0);
      mon_en = 1;

      for (int r = 0; r < 13; r++) begin
         if (tbl[r].rst) do_reset();
         cyc_in(tbl[r].lv, tbl[r].tk, tbl[r].rdy, 0);
         chk($sformatf("tbl%0d_valid", r), 32'(cmd_valid), 32'(tbl[r].ev));
         chk($sformatf("tbl%0d_pending", r), 32'(pending), 32'(tbl[r].ep));
         chk($sformatf("tbl%0d_overflow", r), 32'(overflow), 0);
         if (tbl[r].ev) begin
            chk($sformatf("tbl%0d_id", r), 32'(cmd_id), 32'(tbl[r].eid));
            chk($sformatf("tbl%0d_long", r), 32'(cmd_long), 32'(tbl[r].el));
         end
      end

      // btn 1 held 20 cycles: long command LONG cycles after the tick edge
      do_reset();
      cyc_in(4'b0010, 4'b0010, 1, 0);
      waited = 0;
      while (!cmd_valid && waited < 30) begin
         cyc_in(4'b0010, 4'b0000, 1, 0);
         waited++;
      end
      chk("long_latency", 32'(waited), 32'(LONG));
      chk("long_id", 32'(cmd_id), 1);
      chk("long_type", 32'(cmd_long), 1);
      seen = 0;
      for (int c = 0; c < 11; c++) begin
         cyc_in(4'b0010, 4'b0000, 1, 0);
         seen |= cmd_valid;
      end
      for (int c = 0; c < 6; c++) begin
         cyc_in(4'b0000, 4'b0000, 1, 0);
         seen |= cmd_valid | (|pending);
      end
      chk("long_no_release_event", 32'(seen), 0);

      // stall with btn 1 on the port; btn 0 pressed twice -> one drop
      do_reset();
      cyc_in(4'b0010, 4'b0010, 0, 0);
      cyc_in(4'b0000, 4'b0000, 0, 0);
      cyc_in(4'b0000, 4'b0000, 0, 0);
      cyc_in(4'b0001, 4'b0001, 0, 0);
      cyc_in(4'b0000, 4'b0000, 0, 0);
      chk("stall_pend0", 32'(pending), 4'b0001);
      cyc_in(4'b0001, 4'b0001, 0, 0);
      cyc_in(4'b0000, 4'b0000, 0, 0);
      chk("stall_overflow_set", 32'(overflow), 1);
      for (int c = 0; c < 10; c++) begin
         cyc_in(4'b0000, 4'b0000, 0, 0);
         chk("stall_valid", 32'(cmd_valid), 1);
         chk("stall_id", 32'(cmd_id), 1);
         chk("stall_long", 32'(cmd_long), 0);
      end
      cyc_in(4'b0000, 4'b0000, 0, 1);
      chk("stall_overflow_clr", 32'(overflow), 0);
      cyc_in(4'b0000, 4'b0000, 1, 0);
      chk("stall_next_id", 32'(cmd_id), 0);
      chk("stall_next_valid", 32'(cmd_valid), 1);
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         cyc_in(4'b0000, 4'b0000, 1, 0);
         seen |= cmd_valid;
      end
      chk("stall_single_btn0", 32'(seen), 0);

      // grant of btn 2 in the same cycle btn 2 posts a long event
      do_reset();
      cyc_in(4'b0010, 4'b0010, 0, 0);
      cyc_in(4'b0000, 4'b0000, 0, 0);
      cyc_in(4'b0000, 4'b0000, 0, 0);
      cyc_in(4'b0100, 4'b0100, 0, 0);
      cyc_in(4'b0000, 4'b0000, 0, 0);
      cyc_in(4'b0100, 4'b0100, 0, 0);
      for (int c = 0; c < LONG - 2; c++) cyc_in(4'b0100, 4'b0000, 0, 0);
      cyc_in(4'b0100, 4'b0000, 1, 0);
      chk("collide_id", 32'(cmd_id), 2);
      chk("collide_long", 32'(cmd_long), 0);
      chk("collide_pend", 32'(pending), 4'b0100);
      chk("collide_overflow", 32'(overflow), 0);
      cyc_in(4'b0100, 4'b0000, 1, 0);
      chk("collide_next_id", 32'(cmd_id), 2);
      chk("collide_next_long", 32'(cmd_long), 1);
      chk("collide_next_valid", 32'(cmd_valid), 1);
      cyc_in(4'b0000, 4'b0000, 1, 0);
      chk("collide_drain", 32'(cmd_valid), 0);

      // async reset while a command is held and btn 3 is pressed
      do_reset();
      cyc_in(4'b0010, 4'b0010, 0, 0);
      cyc_in(4'b0000, 4'b0000, 0, 0);
      cyc_in(4'b1000, 4'b1000, 0, 0);
      cyc_in(4'b1000, 4'b0000, 0, 0);
      chk("pre_rst_valid", 32'(cmd_valid), 1);
      #2 rst_n = 0;
      #1;
      chk("async_rst_valid", 32'(cmd_valid), 0);
      chk("async_rst_pending", 32'(pending), 0);
      chk("async_rst_id", 32'(cmd_id), 0);
      @(negedge clk);
      rst_n = 1;
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         cyc_in(4'b1000, 4'b0000, 1, 0);
         seen |= cmd_valid | (|pending);
      end
      chk("post_rst_no_event", 32'(seen), 0);
      cyc_in(4'b0000, 4'b0000, 1, 0);

      // random activity against the model
      lv = '0;
      for (int n = 0; n < 3000; n++) begin
         tk = '0;
         for (int i = 0; i < NBTN; i++) begin
            if (!lv[i]) begin
               if ($urandom_range(5) == 0) begin lv[i] = 1; tk[i] = 1; end
            end else if ($urandom_range(9) == 0) lv[i] = 0;
            else if ($urandom_range(19) == 0) tk[i] = 1;
         end
         cyc_in(lv, tk, $urandom_range(3) != 0, $urandom_range(29) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1);
   end
endmodule
